// File: rtl/axis_arb_pkg.sv
// axis_channel_arbiter shared types and constants.
// AXIS_ARB_HDR_EN adds a header beat ahead of each packet.
package axis_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      BURST
   } arb_state_e;

   localparam logic [15:0] HDR_MAGIC = 16'hA5C0;

endpackage

// File: rtl/axis_arb_rr_pick.sv
// Round-robin picker: first requester after ptr, wrapping.
// Purely combinational.
module axis_arb_rr_pick
   import axis_arb_pkg::*;
#(
   parameter  int NUM_CH  = 2,
   localparam int CH_BITS = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0]  req_i,
   input  logic [CH_BITS-1:0] ptr_i,
   output logic [CH_BITS-1:0] gnt_idx_o,
   output logic               gnt_any_o
);

   logic [CH_BITS-1:0] idx;

   always_comb begin
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      idx       = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = CH_BITS'((int'(ptr_i) + i) % NUM_CH);
         if (!gnt_any_o && req_i[idx]) begin
            gnt_idx_o = idx;
            gnt_any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_channel_arbiter.sv
// Packet-locked round-robin AXI4-Stream arbiter, one output register.
// AXIS_ARB_HDR_EN prepends a header beat to every packet.
module axis_channel_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int NUM_CH     = 2,
   parameter  int DATA_WIDTH = 128,
   parameter  int DEST_WIDTH = 32,
   localparam int CH_BITS    = $clog2(NUM_CH)
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic [NUM_CH-1:0]                  ch_valid,
   output logic [NUM_CH-1:0]                  ch_ready,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  ch_data,
   input  logic [NUM_CH-1:0]                  ch_last,
   output logic [DATA_WIDTH-1:0]              stream_tdata,
   output logic                               stream_tvalid,
   input  logic                               stream_tready,
   output logic                               stream_tlast,
   output logic [DEST_WIDTH-1:0]              stream_tdest,
   output logic [DATA_WIDTH/8-1:0]            stream_tkeep,
   output logic [CH_BITS-1:0]                 grant_id,
   output logic                               busy
);

   arb_state_e          state_q;
   logic [CH_BITS-1:0]  ptr_q;
   logic [CH_BITS-1:0]  grant_q;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic                tvalid_q;
   logic                tlast_q;
   logic [DEST_WIDTH-1:0] tdest_q;

   logic                out_free;
   logic                beat_xfer;
   logic [CH_BITS-1:0]  pick_idx;
   logic                pick_any;

   axis_arb_rr_pick #(
      .NUM_CH (NUM_CH)
   ) u_pick (
      .req_i     (ch_valid),
      .ptr_i     (ptr_q),
      .gnt_idx_o (pick_idx),
      .gnt_any_o (pick_any)
   );

   assign out_free  = ~tvalid_q | stream_tready;
   assign beat_xfer = (state_q == BURST) & out_free & ch_valid[grant_q];
   assign ch_ready  = (state_q == BURST && out_free) ?
                      NUM_CH'(1) << grant_q : '0;

`ifdef AXIS_ARB_HDR_EN
   logic [DATA_WIDTH-1:0] hdr_beat;

   always_comb begin
      hdr_beat       = '0;
      hdr_beat[23:0] = {HDR_MAGIC, 8'(grant_q)};
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         ptr_q    <= CH_BITS'(NUM_CH - 1);
         grant_q  <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdest_q  <= '0;
      end else begin
         // a load below overrides this drain
         if (stream_tready) tvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  grant_q <= pick_idx;
`ifdef AXIS_ARB_HDR_EN
                  state_q <= HDR;
`else
                  state_q <= BURST;
`endif
               end
            end
`ifdef AXIS_ARB_HDR_EN
            HDR: begin
               if (out_free) begin
                  tdata_q  <= hdr_beat;
                  tlast_q  <= 1'b0;
                  tdest_q  <= DEST_WIDTH'(grant_q);
                  tvalid_q <= 1'b1;
                  state_q  <= BURST;
               end
            end
`endif
            BURST: begin
               if (beat_xfer) begin
                  tdata_q  <= ch_data[grant_q];
                  tlast_q  <= ch_last[grant_q];
                  tdest_q  <= DEST_WIDTH'(grant_q);
                  tvalid_q <= 1'b1;
                  if (ch_last[grant_q]) begin
                     ptr_q   <= grant_q;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stream_tdata  = tdata_q;
   assign stream_tvalid = tvalid_q;
   assign stream_tlast  = tlast_q;
   assign stream_tdest  = tdest_q;
   assign stream_tkeep  = '1;
   assign grant_id      = grant_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_axis_channel_arbiter.sv
// Randomized bench for axis_channel_arbiter with per-channel scoreboards.
// Honours AXIS_ARB_HDR_EN for header-beat expectations.
module tb_axis_channel_arbiter;

   localparam int NUM_CH = 2;
   localparam int DW     = 128;
   localparam int DEW    = 32;
   localparam int CB     = 1;
`ifdef AXIS_ARB_HDR_EN
   localparam int HDR_N  = 1;
`else
   localparam int HDR_N  = 0;
`endif

   typedef struct packed {
      logic [DW-1:0]  data;
      logic           last;
      logic [DEW-1:0] dest;
   } beat_t;

   logic                       clk;
   logic                       resetn;
   logic [NUM_CH-1:0]          ch_valid;
   logic [NUM_CH-1:0]          ch_ready;
   logic [NUM_CH-1:0][DW-1:0]  ch_data;
   logic [NUM_CH-1:0]          ch_last;
   logic [DW-1:0]              stream_tdata;
   logic                       stream_tvalid;
   logic                       stream_tready;
   logic                       stream_tlast;
   logic [DEW-1:0]             stream_tdest;
   logic [DW/8-1:0]            stream_tkeep;
   logic [CB-1:0]              grant_id;
   logic                       busy;

   beat_t src_q [NUM_CH][$];
   beat_t exp_q [NUM_CH][$];
   beat_t out_log[$];
   int    pkt_order[$];
   int    pkt_cyc[$];
   bit    rdy_pat[$];
   int    n_cmp;
   int    n_bad;

   axis_channel_arbiter #(
      .NUM_CH     (NUM_CH),
      .DATA_WIDTH (DW),
      .DEST_WIDTH (DEW)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .ch_valid      (ch_valid),
      .ch_ready      (ch_ready),
      .ch_data       (ch_data),
      .ch_last       (ch_last),
      .stream_tdata  (stream_tdata),
      .stream_tvalid (stream_tvalid),
      .stream_tready (stream_tready),
      .stream_tlast  (stream_tlast),
      .stream_tdest  (stream_tdest),
      .stream_tkeep  (stream_tkeep),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] hdr_word(input int c);
      logic [DW-1:0] w;
      w        = '0;
      w[23:8]  = 16'hA5C0;
      w[7:0]   = 8'(c);
      return w;
   endfunction

   function automatic bit work_done();
      for (int c = 0; c < NUM_CH; c++)
         if (src_q[c].size() != 0 || exp_q[c].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic push_pkt(input int c, input int len,
                           input logic [DW-1:0] base,
                           input logic [DW-1:0] step);
      beat_t b;
      if (HDR_N != 0) begin
         b.data = hdr_word(c);
         b.last = 1'b0;
         b.dest = DEW'(c);
         exp_q[c].push_back(b);
      end
      for (int i = 0; i < len; i++) begin
         b.data = base + step * DW'(i);
         b.last = (i == len - 1);
         b.dest = DEW'(c);
         src_q[c].push_back(b);
         exp_q[c].push_back(b);
      end
   endtask

   task automatic do_reset();
      resetn        = 1'b0;
      ch_valid      = '0;
      ch_last       = '0;
      ch_data       = '0;
      stream_tready = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         src_q[c].delete();
         exp_q[c].delete();
      end
      out_log.delete();
      pkt_order.delete();
      pkt_cyc.delete();
      rdy_pat.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_traffic(input int vprob, input int rprob,
                              input int d0, input int max_cyc);
      bit                acc [NUM_CH];
      int                locked;
      int                out_ch;
      bit                prev_stall;
      logic [DW-1:0]     p_data;
      logic              p_last;
      logic [DEW-1:0]    p_dest;
      logic [NUM_CH-1:0] allowed;
      beat_t             e;
      int                d;
      int                k;
      locked     = -1;
      out_ch     = -1;
      prev_stall = 1'b0;
      p_data     = '0;
      p_last     = 1'b0;
      p_dest     = '0;
      k          = 0;
      for (int c = 0; c < NUM_CH; c++) acc[c] = 1'b0;
      while (k < max_cyc && !work_done()) begin
         @(negedge clk);
         allowed = (locked >= 0) ? NUM_CH'(1) << locked : '1;
         n_cmp++;
         if ($countones(ch_ready) > 1 || (ch_ready & ~allowed) != '0) begin
            n_bad++;
            $display("FAIL ready_lock: ch_ready=%b allowed=%b", ch_ready, allowed);
         end
         if (stream_tvalid && !stream_tready) begin
            n_cmp++;
            if (ch_ready !== '0) begin
               n_bad++;
               $display("FAIL ready_full: ch_ready=%b want 0", ch_ready);
            end
         end
         if (prev_stall) begin
            n_cmp++;
            if (stream_tvalid !== 1'b1 || stream_tdata !== p_data ||
                stream_tlast !== p_last || stream_tdest !== p_dest) begin
               n_bad++;
               $display("FAIL stall_hold: v=%b d=%h l=%b t=%0d want d=%h l=%b t=%0d",
                        stream_tvalid, stream_tdata, stream_tlast, stream_tdest,
                        p_data, p_last, p_dest);
            end
         end
         prev_stall = stream_tvalid & ~stream_tready;
         p_data     = stream_tdata;
         p_last     = stream_tlast;
         p_dest     = stream_tdest;
         for (int c = 0; c < NUM_CH; c++) begin
            acc[c] = ch_valid[c] & ch_ready[c];
            if (acc[c] && src_q[c].size() != 0) begin
               e      = src_q[c].pop_front();
               locked = e.last ? -1 : c;
            end
         end
         if (stream_tvalid && stream_tready) begin
            d = int'(stream_tdest);
            n_cmp++;
            if (d < 0 || d >= NUM_CH || exp_q[d].size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_beat: tdest=%0d data=%h", stream_tdest, stream_tdata);
            end else begin
               e = exp_q[d].pop_front();
               if (stream_tdata !== e.data || stream_tlast !== e.last ||
                   stream_tkeep !== '1) begin
                  n_bad++;
                  $display("FAIL beat ch%0d: data=%h last=%b keep=%h want data=%h last=%b",
                           d, stream_tdata, stream_tlast, stream_tkeep, e.data, e.last);
               end
            end
            if (out_ch >= 0) begin
               n_cmp++;
               if (d != out_ch) begin
                  n_bad++;
                  $display("FAIL interleave: tdest=%0d want %0d", d, out_ch);
               end
            end else begin
               pkt_order.push_back(d);
               pkt_cyc.push_back(k);
            end
            out_log.push_back('{stream_tdata, stream_tlast, stream_tdest});
            out_ch = stream_tlast ? -1 : d;
         end
         @(posedge clk);
         #1;
         for (int c = 0; c < NUM_CH; c++) begin
            if (!ch_valid[c] || acc[c]) begin
               if (src_q[c].size() != 0 && k >= (c == 0 ? d0 : 0) &&
                   $urandom_range(99) < vprob) begin
                  ch_valid[c] = 1'b1;
                  ch_data[c]  = src_q[c][0].data;
                  ch_last[c]  = src_q[c][0].last;
               end else begin
                  ch_valid[c] = 1'b0;
               end
            end
         end
         if (rdy_pat.size() != 0) stream_tready = rdy_pat.pop_front();
         else stream_tready = ($urandom_range(99) < rprob);
         k++;
      end
      n_cmp++;
      if (!work_done()) begin
         n_bad++;
         $display("FAIL timeout: %0d cycles, src0=%0d src1=%0d exp0=%0d exp1=%0d want all 0",
                  k, src_q[0].size(), src_q[1].size(), exp_q[0].size(), exp_q[1].size());
      end
      ch_valid = '0;
   endtask

   task automatic test_reset();
      resetn        = 1'b0;
      ch_valid      = 2'b11;
      ch_last       = '0;
      ch_data       = '1;
      stream_tready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         n_cmp++;
         if (stream_tvalid !== 1'b0 || stream_tlast !== 1'b0 ||
             stream_tdata !== '0 || stream_tdest !== '0 ||
             ch_ready !== '0 || busy !== 1'b0 || grant_id !== '0) begin
            n_bad++;
            $display("FAIL reset_state: v=%b l=%b d=%h t=%0d rdy=%b busy=%b g=%0d want all 0",
                     stream_tvalid, stream_tlast, stream_tdata, stream_tdest,
                     ch_ready, busy, grant_id);
         end
      end
      ch_valid = '0;
   endtask

   task automatic test_rotation();
      int exp_order[3] = '{0, 1, 0};
      do_reset();
      push_pkt(0, 3, 128'h100, 128'h1);
      push_pkt(1, 3, 128'h200, 128'h1);
      push_pkt(0, 3, 128'h300, 128'h1);
      run_traffic(100, 100, 0, 200);
      n_cmp++;
      if (pkt_order.size() != 3) begin
         n_bad++;
         $display("FAIL rot_count: packets=%0d want 3", pkt_order.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pkt_order[i] != exp_order[i]) begin
               n_bad++;
               $display("FAIL rot_order[%0d]: ch=%0d want %0d", i, pkt_order[i], exp_order[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (pkt_cyc[i] - pkt_cyc[i-1] != 3 + 1 + HDR_N) begin
               n_bad++;
               $display("FAIL rot_gap[%0d]: %0d cycles want %0d",
                        i, pkt_cyc[i] - pkt_cyc[i-1], 3 + 1 + HDR_N);
            end
         end
      end
   endtask

   task automatic test_lock();
      do_reset();
      push_pkt(1, 4, 128'hA0, 128'h1);
      push_pkt(0, 2, 128'hB0, 128'h1);
      run_traffic(100, 100, 2, 200);
      n_cmp++;
      if (pkt_order.size() != 2 || pkt_order[0] != 1 || pkt_order[1] != 0) begin
         n_bad++;
         $display("FAIL lock_order: n=%0d first=%0d want n=2 order 1,0",
                  pkt_order.size(), pkt_order.size() ? pkt_order[0] : -1);
      end
   endtask

   task automatic test_stall();
      do_reset();
      push_pkt(0, 3, 128'h11, 128'h11);
      rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      run_traffic(100, 100, 0, 200);
      n_cmp++;
      if (out_log.size() != 3 + HDR_N) begin
         n_bad++;
         $display("FAIL stall_count: beats=%0d want %0d", out_log.size(), 3 + HDR_N);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      int acc;
      int k;
      d0 = 128'h5000;
      d1 = 128'h6000;
      do_reset();
      stream_tready = 1'b1;
      ch_valid[0]   = 1'b1;
      ch_data[0]    = d0;
      ch_last[0]    = 1'b0;
      acc = 0;
      k   = 0;
      while (acc < 2 && k < 20) begin
         @(negedge clk);
         if (ch_valid[0] && ch_ready[0]) acc++;
         @(posedge clk);
         #1;
         ch_data[0] = d0 + DW'(acc);
         k++;
      end
      n_cmp++;
      if (stream_tvalid !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_pre: tvalid=%b busy=%b want 1 1", stream_tvalid, busy);
      end
      resetn = 1'b0;
      #1;
      n_cmp++;
      if (stream_tvalid !== 1'b0 || busy !== 1'b0 || ch_ready !== '0 ||
          stream_tlast !== 1'b0 || stream_tdata !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: v=%b busy=%b rdy=%b l=%b d=%h want 0",
                  stream_tvalid, busy, ch_ready, stream_tlast, stream_tdata);
      end
      ch_valid   = 2'b11;
      ch_data[0] = d0;
      ch_data[1] = d1;
      ch_last    = 2'b11;
      @(negedge clk);
      resetn = 1'b1;
      k = 0;
      while (!stream_tvalid && k < 10) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (stream_tvalid !== 1'b1 || stream_tdest !== '0 || grant_id !== '0 ||
          (HDR_N == 0 && stream_tdata !== d0) ||
          (HDR_N != 0 && stream_tdata !== hdr_word(0))) begin
         n_bad++;
         $display("FAIL mid_regrant: v=%b t=%0d g=%0d d=%h want ch0 first",
                  stream_tvalid, stream_tdest, grant_id, stream_tdata);
      end
      ch_valid = '0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_hdr();
      logic [DW-1:0] w0;
      logic          l0;
      int            n;
`ifdef AXIS_ARB_HDR_EN
      w0 = 128'h00A5C001;
      l0 = 1'b0;
`else
      w0 = 128'hDEAD;
      l0 = 1'b1;
`endif
      do_reset();
      push_pkt(1, 1, 128'hDEAD, 128'h0);
      run_traffic(100, 100, 0, 100);
      n = out_log.size();
      n_cmp++;
      if (n != 1 + HDR_N) begin
         n_bad++;
         $display("FAIL hdr_count: beats=%0d want %0d", n, 1 + HDR_N);
      end else begin
         n_cmp++;
         if (out_log[0].data !== w0 || out_log[0].last !== l0 || out_log[0].dest !== 1) begin
            n_bad++;
            $display("FAIL hdr_first: d=%h l=%b t=%0d want d=%h l=%b t=1",
                     out_log[0].data, out_log[0].last, out_log[0].dest, w0, l0);
         end
         n_cmp++;
         if (out_log[n-1].data !== 128'hDEAD || out_log[n-1].last !== 1'b1 ||
             out_log[n-1].dest !== 1) begin
            n_bad++;
            $display("FAIL hdr_payload: d=%h l=%b t=%0d want DEAD 1 1",
                     out_log[n-1].data, out_log[n-1].last, out_log[n-1].dest);
         end
      end
   endtask

   task automatic test_random();
      int total;
      int npk;
      int len;
      int c;
      do_reset();
      total = 0;
      npk   = 40;
      for (int p = 0; p < npk; p++) begin
         c   = $urandom_range(NUM_CH - 1);
         len = $urandom_range(6, 1);
         push_pkt(c, len, {$urandom, $urandom, $urandom, $urandom},
                  DW'($urandom_range(255, 1)));
         total += len + HDR_N;
      end
      run_traffic(60, 60, 0, 5000);
      n_cmp++;
      if (out_log.size() != total || pkt_order.size() != npk) begin
         n_bad++;
         $display("FAIL rand_totals: beats=%0d pkts=%0d want %0d %0d",
                  out_log.size(), pkt_order.size(), total, npk);
      end
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      resetn        = 1'b0;
      ch_valid      = '0;
      ch_data       = '0;
      ch_last       = '0;
      stream_tready = 1'b0;
      test_reset();
      test_rotation();
      test_lock();
      test_stall();
      test_reset_mid();
      test_hdr();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
